mem_dump: RTL and testbench
===========================

MEM_DUMP -- requirements
Module: mem_dump

Interface
REQ-001 SHALL have parameter CLOCK_RATE, default 12_000_000, meaning clock frequency in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 115200, meaning UART bit rate.
REQ-003 SHALL have port clk  input  1  clock; one clock domain, all logic on posedge clk.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port start  input  1  request a dump; sampled only in IDLE.
REQ-006 SHALL have port base  input  11  first word address, latched on an accepted start.
REQ-007 SHALL have port count  input  12  number of 32-bit words, latched on an accepted start; 0 is legal.
REQ-008 SHALL have port busy  output  1  high from accepted start until done.
REQ-009 SHALL have port done  output  1  one-cycle completion pulse.
REQ-010 SHALL have port mem_valid  output  1  read strobe to BRAM, never a write.
REQ-011 SHALL have port mem_addr  output  11  BRAM word address.
REQ-012 SHALL have port mem_rdata  input  32  BRAM read data, valid one cycle after mem_addr (registered read).
REQ-013 SHALL have port tx  output  1  UART 8N1 serial output, idle high.

Function
REQ-014 SHALL implement states IDLE, READ, CAPTURE, SEND, NEXT.
REQ-015 IDLE: start=1 at edge N SHALL latch base/count and set busy=1 from cycle N+1; start while busy SHALL be ignored.
REQ-016 count=0: SHALL go straight to done; done=1 in cycle N+1, busy=0 in cycle N+2; no mem_valid, tx stays 1.
REQ-017 READ: SHALL drive mem_valid=1 and mem_addr=current address for exactly one cycle (N+1 for the first word).
REQ-018 CAPTURE: SHALL register mem_rdata in the following cycle into a 32-bit shift buffer.
REQ-019 SEND: SHALL transmit 4 bytes little-endian (rdata[7:0] first), each as start bit 0, 8 data bits LSB first, stop bit 1.
REQ-020 Bit period SHALL be CLKS_PER_BIT = CLOCK_RATE/BAUD_RATE (integer division; 104 at defaults); one frame = 10*CLKS_PER_BIT cycles.
REQ-021 First start bit SHALL appear on tx in the cycle after CAPTURE; successive bytes of one word SHALL follow back-to-back with no idle gap.
REQ-022 NEXT: SHALL increment address modulo 2048 (0x7FF -> 0x000) and decrement remaining count; if remaining >0 go to READ, else done.
REQ-023 Inter-word gap SHALL be exactly 3 idle-high cycles (NEXT, READ, CAPTURE).
REQ-024 done SHALL pulse for one cycle after the last stop bit's final cycle; busy SHALL be 0 in the cycle after done.
REQ-025 mem_valid SHALL be 0 in every state other than READ; mem_addr SHALL hold its last value otherwise.

Reset
REQ-026 rst=1 at any edge SHALL force IDLE, busy=0, done=0, mem_valid=0, mem_addr=0, tx=1 from the next cycle, aborting any frame mid-bit.
REQ-027 Bit counter, baud counter, byte index and remaining count SHALL reset to 0.

Structure
REQ-028 Shared package mem_dump_pkg SHALL hold the state encoding and the CLKS_PER_BIT computation.
REQ-029 One sub-module uart_tx_byte SHALL implement the 8N1 serializer (inputs clk, rst, send, data[7:0]; outputs tx, ready); mem_dump SHALL sequence bytes into it.

Verification
REQ-030 mem[0x780]=0x12345678, base=0x780, count=1, start -> mem_valid one cycle with addr 0x780; tx bytes 0x78,0x56,0x34,0x12; done 4*1040 cycles after first start bit.
REQ-031 base=0x7FF, count=2, mem[0x7FF]=0xA5A5A5A5, mem[0]=0x000000FF -> reads 0x7FF then 0x000; bytes A5 A5 A5 A5 FF 00 00 00; 3-cycle idle gap between words.
REQ-032 count=0, start -> done one cycle later, no mem_valid, tx constant 1.
REQ-033 start pulsed repeatedly during an active count=1 dump -> exactly one dump, one done pulse.
REQ-034 rst asserted mid-second data bit of byte 2 -> tx=1, busy=0 next cycle; new start afterwards produces a clean full dump.
REQ-035 Bench UART receiver sampling mid-bit at 104-cycle period SHALL decode every byte with no framing error.

Source files
------------

// File: rtl/mem_dump_pkg.sv
// Shared definitions for the BRAM-to-UART dump engine: sequencer states and
// bit-period derivation.
package mem_dump_pkg;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    CAPTURE,
    SEND,
    NEXT
  } state_t;

  localparam int BAUD_W = 16;

  function automatic int clks_per_bit(int clock_rate, int baud_rate);
    return clock_rate / baud_rate;
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 serializer. ready also rises in the final cycle of the stop bit so a
// queued byte starts with no idle gap.
module uart_tx_byte
  import mem_dump_pkg::*;
#(
  parameter int CLKS_PER_BIT = 104
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       send,
  input  logic [7:0] data,
  output logic       tx,
  output logic       ready
);

  logic              active;
  logic [3:0]        bit_cnt;
  logic [BAUD_W-1:0] baud_cnt;
  logic [8:0]        shreg;
  logic              bit_end;

  assign bit_end = (baud_cnt == BAUD_W'(CLKS_PER_BIT - 1));
  assign ready   = !active || (bit_cnt == 4'd9 && bit_end);

  always_ff @(posedge clk) begin
    if (rst) begin
      active   <= 1'b0;
      bit_cnt  <= '0;
      baud_cnt <= '0;
      shreg    <= '1;
      tx       <= 1'b1;
    end else if (send && ready) begin
      active   <= 1'b1;
      bit_cnt  <= '0;
      baud_cnt <= '0;
      shreg    <= {1'b1, data};
      tx       <= 1'b0;
    end else if (active) begin
      if (bit_end) begin
        baud_cnt <= '0;
        if (bit_cnt == 4'd9) begin
          active  <= 1'b0;
          bit_cnt <= '0;
          tx      <= 1'b1;
        end else begin
          // stop bit falls out of shreg after the eight data bits
          bit_cnt <= bit_cnt + 4'd1;
          tx      <= shreg[0];
          shreg   <= {1'b1, shreg[8:1]};
        end
      end else begin
        baud_cnt <= baud_cnt + BAUD_W'(1);
      end
    end
  end

endmodule

// File: rtl/mem_dump.sv
// Reads count words from BRAM starting at base and streams each one out of
// the UART as four little-endian bytes.
module mem_dump
  import mem_dump_pkg::*;
#(
  parameter int CLOCK_RATE = 12_000_000,
  parameter int BAUD_RATE  = 115200
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [10:0] base,
  input  logic [11:0] count,
  output logic        busy,
  output logic        done,
  output logic        mem_valid,
  output logic [10:0] mem_addr,
  input  logic [31:0] mem_rdata,
  output logic        tx
);

  localparam int CLKS_PER_BIT = clks_per_bit(CLOCK_RATE, BAUD_RATE);

  state_t      state;
  logic [11:0] remaining;
  logic [2:0]  byte_idx;
  logic [31:0] shbuf;
  logic        send;
  logic [7:0]  send_data;
  logic        ready;

  // byte 0 goes straight from mem_rdata so its start bit follows CAPTURE
  always_comb begin
    send      = 1'b0;
    send_data = shbuf[7:0];
    if (state == CAPTURE) begin
      send      = 1'b1;
      send_data = mem_rdata[7:0];
    end else if (state == SEND && ready && byte_idx != 3'd4) begin
      send = 1'b1;
    end
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx (
    .clk  (clk),
    .rst  (rst),
    .send (send),
    .data (send_data),
    .tx   (tx),
    .ready(ready)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      mem_valid <= 1'b0;
      mem_addr  <= '0;
      remaining <= '0;
      byte_idx  <= '0;
      shbuf     <= '0;
    end else begin
      done      <= 1'b0;
      mem_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            busy      <= 1'b1;
            mem_addr  <= base;
            remaining <= count;
            if (count == '0) begin
              state <= NEXT;
              done  <= 1'b1;
            end else begin
              state     <= READ;
              mem_valid <= 1'b1;
            end
          end
        end
        READ: state <= CAPTURE;
        CAPTURE: begin
          shbuf    <= {8'h00, mem_rdata[31:8]};
          byte_idx <= 3'd1;
          state    <= SEND;
        end
        SEND: begin
          if (ready) begin
            if (byte_idx == 3'd4) begin
              // done is raised here so it lands in the NEXT cycle
              byte_idx <= '0;
              done     <= (remaining <= 12'd1);
              state    <= NEXT;
            end else begin
              shbuf    <= {8'h00, shbuf[31:8]};
              byte_idx <= byte_idx + 3'd1;
            end
          end
        end
        NEXT: begin
          if (remaining != '0) remaining <= remaining - 12'd1;
          if (remaining > 12'd1) begin
            mem_addr  <= mem_addr + 11'd1;
            mem_valid <= 1'b1;
            state     <= READ;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_dump.sv
// Self-checking bench for mem_dump: BRAM model, mid-bit UART receiver and a
// timing/byte-stream reference computed from the dump rules.
module tb_mem_dump;

  localparam int CLOCK_RATE = 12_000_000;
  localparam int BAUD_RATE  = 115200;
  localparam int CPB        = CLOCK_RATE / BAUD_RATE;
  localparam int FRAME      = 10 * CPB;
  localparam int WORD_T     = 4 * FRAME + 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [10:0] base;
  logic [11:0] count;
  logic        busy;
  logic        done;
  logic        mem_valid;
  logic [10:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        tx;

  logic [31:0] mem [2048];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [10:0] rd_q[$];
  int          rd_cyc_q[$];
  int          done_q[$];
  logic [7:0]  rx_q[$];
  int          rx_cyc_q[$];
  int          tx_low;

  bit          rx_on = 1'b0;
  int          rx_n, rx_idx, rx_t0;
  logic [7:0]  rx_sh;

  mem_dump #(
    .CLOCK_RATE(CLOCK_RATE),
    .BAUD_RATE (BAUD_RATE)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .base     (base),
    .count    (count),
    .busy     (busy),
    .done     (done),
    .mem_valid(mem_valid),
    .mem_addr (mem_addr),
    .mem_rdata(mem_rdata),
    .tx       (tx)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (mem_valid === 1'b1) mem_rdata <= mem[mem_addr];
    else                    mem_rdata <= 32'hxxxx_xxxx;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mem_valid === 1'b1) begin
      rd_q.push_back(mem_addr);
      rd_cyc_q.push_back(cyc);
    end
    if (done === 1'b1) done_q.push_back(cyc);
    if (tx === 1'b0) tx_low++;
    if (rst === 1'b1) rx_on = 1'b0;
    else if (!rx_on) begin
      if (tx === 1'b0) begin
        rx_on = 1'b1;
        rx_n  = 0;
        rx_t0 = cyc;
      end
    end else begin
      rx_n++;
      if (rx_n >= CPB / 2 && (rx_n - CPB / 2) % CPB == 0) begin
        rx_idx = (rx_n - CPB / 2) / CPB;
        if (rx_idx == 0) check("rx_start_bit", 64'(tx), 64'd0);
        else if (rx_idx <= 8) rx_sh[rx_idx-1] = tx;
        else begin
          check("rx_stop_bit", 64'(tx), 64'd1);
          rx_q.push_back(rx_sh);
          rx_cyc_q.push_back(rx_t0);
          rx_on = 1'b0;
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_mon();
    rd_q.delete();
    rd_cyc_q.delete();
    done_q.delete();
    rx_q.delete();
    rx_cyc_q.delete();
    tx_low = 0;
  endtask

  task automatic run_dump(input string name, input logic [10:0] b, input logic [11:0] c,
                          input bit pulse_start);
    logic [7:0]  exp_b[$];
    logic [10:0] exp_a[$];
    logic [10:0] a;
    logic [31:0] w;
    int t, s0, exp_done, budget, n;
    clear_mon();
    base  = b;
    count = c;
    start = 1'b1;
    t     = cyc + 1;
    tick();
    check({name, ":busy_at_accept"}, 64'(busy), 64'd1);
    start = 1'b0;
    for (int k = 0; k < int'(c); k++) begin
      a = b + 11'(k);
      exp_a.push_back(a);
      w = mem[a];
      for (int j = 0; j < 4; j++) exp_b.push_back(w[8*j +: 8]);
    end
    s0       = t + 2;
    exp_done = (c == 0) ? t : s0 + int'(c) * 4 * FRAME + (int'(c) - 1) * 3;
    budget   = exp_done - cyc + 200;
    for (int i = 0; i < budget && done_q.size() == 0; i++) begin
      if (pulse_start && i < 2000) start = 1'($urandom_range(0, 1));
      tick();
    end
    start = 1'b0;
    check({name, ":done_seen"}, 64'(done_q.size() > 0), 64'd1);
    if (done_q.size() > 0) begin
      check({name, ":done_cycle"}, 64'(done_q[0]), 64'(exp_done));
      check({name, ":busy_at_done"}, 64'(busy), 64'd1);
      tick();
      check({name, ":busy_after_done"}, 64'(busy), 64'd0);
      check({name, ":done_one_cycle"}, 64'(done), 64'd0);
    end
    repeat (20) tick();
    check({name, ":done_pulses"}, 64'(done_q.size()), 64'd1);
    check({name, ":reads"}, 64'(rd_q.size()), 64'(exp_a.size()));
    n = (rd_q.size() < exp_a.size()) ? rd_q.size() : exp_a.size();
    for (int k = 0; k < n; k++) begin
      check({name, ":read_addr"}, 64'(rd_q[k]), 64'(exp_a[k]));
      check({name, ":read_cycle"}, 64'(rd_cyc_q[k]), 64'(t + k * WORD_T));
    end
    check({name, ":bytes"}, 64'(rx_q.size()), 64'(exp_b.size()));
    n = (rx_q.size() < exp_b.size()) ? rx_q.size() : exp_b.size();
    for (int m = 0; m < n; m++) begin
      check({name, ":byte_val"}, 64'(rx_q[m]), 64'(exp_b[m]));
      check({name, ":byte_start"}, 64'(rx_cyc_q[m]), 64'(s0 + (m / 4) * WORD_T + (m % 4) * FRAME));
    end
    if (c == 0) check({name, ":tx_never_low"}, 64'(tx_low), 64'd0);
    else check({name, ":addr_hold"}, 64'(mem_addr), 64'(exp_a[exp_a.size()-1]));
  endtask

  initial begin
    int t, target;
    logic [31:0] w;
    for (int i = 0; i < 2048; i++) mem[i] = $urandom;
    rst   = 1'b1;
    start = 1'b0;
    base  = '0;
    count = '0;
    repeat (3) tick();
    check("rst:busy", 64'(busy), 64'd0);
    check("rst:done", 64'(done), 64'd0);
    check("rst:mem_valid", 64'(mem_valid), 64'd0);
    check("rst:mem_addr", 64'(mem_addr), 64'd0);
    check("rst:tx", 64'(tx), 64'd1);
    rst = 1'b0;
    repeat (2) tick();

    mem[11'h780] = 32'h1234_5678;
    run_dump("single", 11'h780, 12'd1, 1'b0);

    mem[11'h7FF] = 32'hA5A5_A5A5;
    mem[11'h000] = 32'h0000_00FF;
    run_dump("wrap", 11'h7FF, 12'd2, 1'b0);

    run_dump("zero", 11'h123, 12'd0, 1'b0);

    run_dump("restart_ignored", 11'($urandom_range(0, 2047)), 12'd1, 1'b1);

    clear_mon();
    base  = 11'h155;
    count = 12'd1;
    w     = mem[11'h155];
    start = 1'b1;
    t     = cyc + 1;
    tick();
    start  = 1'b0;
    target = t + 2 + 2 * FRAME + 2 * CPB + CPB / 2;
    while (cyc < target) tick();
    check("abort:tx_mid_bit", 64'(tx), 64'(w[17]));
    rst = 1'b1;
    tick();
    check("abort:tx", 64'(tx), 64'd1);
    check("abort:busy", 64'(busy), 64'd0);
    check("abort:done", 64'(done), 64'd0);
    check("abort:mem_valid", 64'(mem_valid), 64'd0);
    check("abort:mem_addr", 64'(mem_addr), 64'd0);
    rst = 1'b0;
    check("abort:bytes_before", 64'(rx_q.size()), 64'd2);
    if (rx_q.size() == 2) begin
      check("abort:byte0", 64'(rx_q[0]), 64'(w[7:0]));
      check("abort:byte1", 64'(rx_q[1]), 64'(w[15:8]));
    end
    repeat (5) tick();
    run_dump("after_abort", 11'h155, 12'd1, 1'b0);

    for (int r = 0; r < 2; r++)
      run_dump("random", 11'($urandom_range(0, 2047)), 12'($urandom_range(1, 2)), 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
